bin_pixel_packer: RTL and testbench
===================================

BIN_PIXEL_PACKER -- requirements
Module: bin_pixel_packer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  PACK_WIDTH  8    bits per packed output word
  FIFO_DEPTH  16   output FIFO entries (power of two, >=2)
  ADDR_WIDTH  16   word-address width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk           in   1           single clock
  reset_p       in   1           reset; synchronous, active-high
  sobel         in   1           binary pixel (1 = edge)
  sobel_valid   in   1           pixel qualifier
  sobel_hsync   in   1           line active, high during a line
  sobel_vsync   in   1           frame active, high during a frame
  wr_data       out  PACK_WIDTH  packed word
  wr_addr       out  ADDR_WIDTH  word address within the frame
  wr_valid      out  1           word available
  wr_ready      in   1           sink accepts the word
  frame_done    out  1           one-cycle pulse at frame end
  overflow      out  1           sticky word-dropped flag

Function
REQ-003 A pixel SHALL be accepted when sobel_valid & sobel_hsync & sobel_vsync are all high at a clk edge.
REQ-004 Packing SHALL be LSB-first: the first accepted pixel of a word goes to bit 0.
REQ-005 When an edge completes a word (the PACK_WIDTH-th pixel is accepted), that word and its address SHALL be pushed into the FIFO at the next edge.
REQ-006 wr_addr SHALL be stored in the FIFO together with its word.
REQ-007 The address counter SHALL start at 0 and increment by 1 per pushed word, wrapping modulo 2^ADDR_WIDTH.
REQ-008 The FIFO SHALL be first-word-fall-through: wr_valid = not empty, and wr_data/wr_addr present the head entry.
REQ-009 A pop SHALL occur on each edge with wr_valid & wr_ready; wr_data/wr_addr SHALL hold stable while wr_valid is high and wr_ready is low.
REQ-010 On a simultaneous push and pop with the FIFO full, both SHALL occur and the FIFO SHALL stay full.
REQ-011 On a push with the FIFO full and no pop, the word SHALL be dropped, the address counter SHALL still increment, and overflow SHALL be set.
REQ-012 overflow SHALL stay set until the next sobel_vsync rising edge or reset.
REQ-013 The FSM SHALL have three states, IDLE, ACTIVE and DRAIN, with these transitions:
  IDLE to ACTIVE on a sobel_vsync rising edge.
  ACTIVE to DRAIN on a sobel_vsync falling edge.
  DRAIN to IDLE when the FIFO is empty.
REQ-014 On a sobel_vsync rising edge, the address counter, the bit counter and overflow SHALL clear; FIFO contents SHALL be preserved.
REQ-015 On the ACTIVE-to-DRAIN transition, a partial word SHALL be zero-padded in its upper bits and pushed.
REQ-016 frame_done SHALL pulse for exactly one cycle on the edge DRAIN leaves on an empty FIFO.
REQ-017 If sobel_vsync rises while in DRAIN, frame_done SHALL pulse that cycle and the FSM SHALL enter ACTIVE; remaining FIFO entries SHALL still drain.
REQ-018 In IDLE, accepted-pixel qualifiers SHALL be ignored.

Reset
REQ-019 On reset_p high at a clk edge, the block SHALL:
  enter IDLE;
  empty the FIFO;
  clear the bit counter, address counter and pack register;
  drive wr_valid=0, frame_done=0, overflow=0, wr_data=0 and wr_addr=0.
REQ-020 Reset mid-frame SHALL discard all pending data, and the block SHALL wait for the next sobel_vsync rising edge.

Configuration
REQ-021 With BIN_PACKER_LINE_PAD_EN defined, a sobel_hsync falling edge with a partial word SHALL zero-pad and push it, and every line SHALL start at bit 0.
REQ-022 Without BIN_PACKER_LINE_PAD_EN, packing SHALL continue across line boundaries, and only the REQ-015 frame-end flush SHALL pad.

Verification
REQ-023 Benches SHALL cover the following directed scenarios:
  Frame with 2 lines x 16 pixels, alternating 1,0 starting with 1, wr_ready=1 -> four words 0x55 at addr 0,1,2,3; frame_done pulses once; overflow=0.
  8 pixels all 1 accepted, wr_ready=0 for 20 cycles -> wr_data=0xFF and wr_addr=0 stay stable; the pop occurs on the first edge with wr_ready=1.
  FIFO_DEPTH=4, wr_ready=0, 6 words pushed -> words at addr 4 and 5 dropped; overflow=1 until the next vsync rise; after release, addr 0..3 are read.
  Line of 12 pixels all 1, macro defined -> words 0xFF, 0x0F; macro undefined, then 12 more 1-pixels -> 0xFF, 0xFF, 0xFF.
  vsync falls after 3 pixels (1,1,0) -> word 0x03 pushed, then frame_done one cycle after the FIFO empties.
  reset_p pulsed mid-line with 5 pixels packed and 2 words queued -> wr_valid=0 next cycle; next frame starts at addr 0, bit 0.

Source files
------------

// File: rtl/bin_pixel_packer_if.sv
// Pixel-in / packed-word-out bus of bin_pixel_packer; the packer sits on the slave modport.
interface bin_pixel_packer_if #(
  parameter int PACK_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  sobel;
  logic                  sobel_valid;
  logic                  sobel_hsync;
  logic                  sobel_vsync;
  logic [PACK_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  frame_done;
  logic                  overflow;

  modport master (
    output sobel, sobel_valid, sobel_hsync, sobel_vsync, wr_ready,
    input  wr_data, wr_addr, wr_valid, frame_done, overflow
  );

  modport slave (
    input  sobel, sobel_valid, sobel_hsync, sobel_vsync, wr_ready,
    output wr_data, wr_addr, wr_valid, frame_done, overflow
  );
endinterface

// File: rtl/bin_pixel_packer.sv
// Packs binary edge pixels LSB-first into words and queues {addr, word} in a FWFT FIFO.
// Define BIN_PACKER_LINE_PAD_EN to zero-pad and flush the partial word at every line end.
module bin_pixel_packer #(
  parameter int PACK_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset_p,
  bin_pixel_packer_if.slave bus
);
  localparam int BW = $clog2(PACK_WIDTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [PACK_WIDTH-1:0] data;
  } entry_t;

  state_t                state;
  logic                  vs_q;
  logic [BW-1:0]         bit_cnt;
  logic [PACK_WIDTH-1:0] pack_q;
  logic [PACK_WIDTH-1:0] word_next;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic                  pend_vld;
  entry_t                pend;
  entry_t                mem [FIFO_DEPTH];
  entry_t                head;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic                  done_q, ovf_q;
  logic                  vs_rise, vs_fall, line_end, accept, last_bit, flush;
  logic                  empty, full, pop, do_push, drop;

  assign vs_rise  = bus.sobel_vsync & ~vs_q;
  assign vs_fall  = ~bus.sobel_vsync & vs_q;
  assign accept   = (state == ACTIVE) & bus.sobel_valid & bus.sobel_hsync & bus.sobel_vsync;
  assign last_bit = (bit_cnt == BW'(PACK_WIDTH - 1));

`ifdef BIN_PACKER_LINE_PAD_EN
  logic hs_q;
  always_ff @(posedge clk) hs_q <= bus.sobel_hsync;
  assign line_end = hs_q & ~bus.sobel_hsync;
`else
  assign line_end = 1'b0;
`endif

  // pack_q keeps unused upper bits at zero, so a flushed partial word is already padded
  assign flush = (state == ACTIVE) & (vs_fall | line_end) & (bit_cnt != '0);

  always_comb begin
    word_next          = pack_q;
    word_next[bit_cnt] = bus.sobel;
  end

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = ~empty & bus.wr_ready;
  assign do_push = pend_vld & (~full | pop);
  assign drop    = pend_vld & full & ~pop;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state    <= IDLE;
      vs_q     <= bus.sobel_vsync;  // a vsync already high is not a new frame start
      bit_cnt  <= '0;
      pack_q   <= '0;
      addr_cnt <= '0;
      pend_vld <= 1'b0;
      pend     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      vs_q     <= bus.sobel_vsync;
      done_q   <= 1'b0;
      pend_vld <= 1'b0;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(pop);
      if (drop) ovf_q <= 1'b1;

      // completed words take their address here; a dropped word still consumes one
      if (accept) begin
        if (last_bit) begin
          pend_vld <= 1'b1;
          pend     <= {addr_cnt, word_next};
          addr_cnt <= addr_cnt + 1'b1;
          bit_cnt  <= '0;
          pack_q   <= '0;
        end else begin
          pack_q  <= word_next;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (flush) begin
        pend_vld <= 1'b1;
        pend     <= {addr_cnt, pack_q};
        addr_cnt <= addr_cnt + 1'b1;
        bit_cnt  <= '0;
        pack_q   <= '0;
      end

      case (state)
        IDLE:    if (vs_rise) state <= ACTIVE;
        ACTIVE:  if (vs_fall) state <= DRAIN;
        DRAIN: begin
          if (vs_rise) begin
            done_q <= 1'b1;
            state  <= ACTIVE;
          end else if (empty && !pend_vld) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (vs_rise) begin
        addr_cnt <= '0;
        bit_cnt  <= '0;
        pack_q   <= '0;
        ovf_q    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= pend;
  end

  assign head           = mem[rd_ptr];
  assign bus.wr_valid   = ~empty;
  assign bus.wr_data    = empty ? '0 : head.data;
  assign bus.wr_addr    = empty ? '0 : head.addr;
  assign bus.frame_done = done_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_bin_pixel_packer.sv
// Scoreboard bench for bin_pixel_packer: expected {addr, word} queued at stimulus, checked on pop.
module tb_bin_pixel_packer;
  localparam int PW    = 8;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_p = 1'b1;
  always #5 clk = ~clk;

  bin_pixel_packer_if #(.PACK_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();
  bin_pixel_packer #(.PACK_WIDTH(PW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_p(reset_p), .bus(bus)
  );

  exp_t exp_q[$];
  exp_t e;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   fd_cnt = 0;

  // a pop happens on the coming posedge whenever valid & ready hold at this negedge
  always @(negedge clk) begin
    if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected got data=%h addr=%h, none expected", bus.wr_data, bus.wr_addr);
      end else begin
        e = exp_q.pop_front();
        if (bus.wr_data !== e.data || bus.wr_addr !== e.addr)
          $display("FAIL pop_word got data=%h addr=%h exp data=%h addr=%h",
                   bus.wr_data, bus.wr_addr, e.data, e.addr);
        else pass_cnt++;
      end
    end
    if (bus.frame_done === 1'b1) fd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic px(input logic b);
    bus.sobel = b;
    bus.sobel_valid = 1'b1;
    tick(1);
    bus.sobel_valid = 1'b0;
    bus.sobel = 1'b0;
  endtask

  task automatic wait_drain(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (exp_q.size() == 0 && bus.wr_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    reset_p = 1'b1;
    tick(3);
    total_cnt++; if (bus.wr_valid !== 1'b0) $display("FAIL reset_wr_valid got=%b exp=0", bus.wr_valid); else pass_cnt++;
    total_cnt++; if (bus.wr_data !== 8'h00) $display("FAIL reset_wr_data got=%h exp=00", bus.wr_data); else pass_cnt++;
    total_cnt++; if (bus.wr_addr !== 16'h0) $display("FAIL reset_wr_addr got=%h exp=0", bus.wr_addr); else pass_cnt++;
    total_cnt++; if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", bus.overflow); else pass_cnt++;
    reset_p = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    logic [AW-1:0] a;
    bit ok;
    a = '0;
    bus.wr_ready = 1'b1;
    fd_cnt = 0;
    bus.sobel_vsync = 1'b1; tick(1);
    for (int l = 0; l < 2; l++) begin
      bus.sobel_hsync = 1'b1;
      for (int i = 0; i < 16; i++) begin
        px(i % 2 == 0);
        if (i % 8 == 7) begin exp_q.push_back({a, 8'h55}); a++; end
      end
      bus.sobel_hsync = 1'b0; tick(1);
    end
    bus.sobel_vsync = 1'b0; tick(1);
    wait_drain(50, ok); tick(4);
    total_cnt++; if (!ok) $display("FAIL basic_drain left=%0d exp=0", exp_q.size()); else pass_cnt++;
    total_cnt++; if (fd_cnt != 1) $display("FAIL basic_frame_done pulses=%0d exp=1", fd_cnt); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL basic_overflow got=%b exp=0", bus.overflow); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit stable;
    bus.wr_ready = 1'b0;
    fd_cnt = 0;
    bus.sobel_vsync = 1'b1; tick(1);
    bus.sobel_hsync = 1'b1;
    for (int i = 0; i < 8; i++) px(1'b1);
    exp_q.push_back({16'd0, 8'hFF});
    tick(1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.wr_valid !== 1'b1 || bus.wr_data !== 8'hFF || bus.wr_addr !== 16'd0) stable = 1'b0;
    end
    total_cnt++; if (!stable) $display("FAIL bp_hold got data=%h addr=%h exp data=ff addr=0", bus.wr_data, bus.wr_addr); else pass_cnt++;
    @(posedge clk); #1;
    bus.wr_ready = 1'b1;
    tick(1);
    total_cnt++; if (bus.wr_valid !== 1'b0) $display("FAIL bp_first_pop wr_valid=%b exp=0", bus.wr_valid); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL bp_popped left=%0d exp=0", exp_q.size()); else pass_cnt++;
    bus.sobel_hsync = 1'b0; bus.sobel_vsync = 1'b0; tick(4);
    total_cnt++; if (fd_cnt != 1) $display("FAIL bp_frame_done pulses=%0d exp=1", fd_cnt); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [PW-1:0] w;
    bit ok;
    bus.wr_ready = 1'b0;
    fd_cnt = 0;
    bus.sobel_vsync = 1'b1; tick(1);
    bus.sobel_hsync = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w = 8'(8'h21 * (k + 1));
      for (int i = 0; i < PW; i++) px(w[i]);
      if (k < DEPTH) exp_q.push_back({16'(k), w});
    end
    tick(2);
    total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set got=%b exp=1", bus.overflow); else pass_cnt++;
    bus.sobel_hsync = 1'b0; bus.sobel_vsync = 1'b0; tick(3);
    total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); else pass_cnt++;
    bus.wr_ready = 1'b1;
    wait_drain(50, ok); tick(3);
    total_cnt++; if (!ok) $display("FAIL ovf_drain left=%0d exp=0", exp_q.size()); else pass_cnt++;
    total_cnt++; if (fd_cnt != 1) $display("FAIL ovf_frame_done pulses=%0d exp=1", fd_cnt); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_before_rise got=%b exp=1", bus.overflow); else pass_cnt++;
    bus.sobel_vsync = 1'b1; tick(1);
    total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clear_on_rise got=%b exp=0", bus.overflow); else pass_cnt++;
    bus.sobel_vsync = 1'b0; tick(3);
  endtask

  task automatic test_line_pad();
    bit ok;
    bus.wr_ready = 1'b1;
    fd_cnt = 0;
`ifdef BIN_PACKER_LINE_PAD_EN
    exp_q.push_back({16'd0, 8'hFF}); exp_q.push_back({16'd1, 8'h0F});
    exp_q.push_back({16'd2, 8'hFF}); exp_q.push_back({16'd3, 8'h0F});
`else
    exp_q.push_back({16'd0, 8'hFF}); exp_q.push_back({16'd1, 8'hFF});
    exp_q.push_back({16'd2, 8'hFF});
`endif
    bus.sobel_vsync = 1'b1; tick(1);
    for (int l = 0; l < 2; l++) begin
      bus.sobel_hsync = 1'b1;
      for (int i = 0; i < 12; i++) px(1'b1);
      bus.sobel_hsync = 1'b0; tick(1);
    end
    bus.sobel_vsync = 1'b0; tick(1);
    wait_drain(50, ok); tick(4);
    total_cnt++; if (!ok) $display("FAIL line_drain left=%0d exp=0", exp_q.size()); else pass_cnt++;
    total_cnt++; if (fd_cnt != 1) $display("FAIL line_frame_done pulses=%0d exp=1", fd_cnt); else pass_cnt++;
  endtask

  task automatic test_flush();
    bit seen;
    bus.wr_ready = 1'b1;
    bus.sobel_vsync = 1'b1; tick(1);
    bus.sobel_hsync = 1'b1;
    px(1'b1); px(1'b1); px(1'b0);
    exp_q.push_back({16'd0, 8'h03});
    bus.sobel_hsync = 1'b0; bus.sobel_vsync = 1'b0; tick(1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (bus.wr_valid === 1'b1) seen = 1'b1; end
    total_cnt++; if (!seen) $display("FAIL flush_push wr_valid never rose, exp 1"); else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (bus.wr_valid === 1'b0) seen = 1'b1; end
    total_cnt++; if (!seen) $display("FAIL flush_empty wr_valid stuck, exp 0"); else pass_cnt++;
    total_cnt++; if (bus.frame_done !== 1'b0) $display("FAIL flush_fd_early got=%b exp=0", bus.frame_done); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.frame_done !== 1'b1) $display("FAIL flush_fd_pulse got=%b exp=1", bus.frame_done); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.frame_done !== 1'b0) $display("FAIL flush_fd_width got=%b exp=0", bus.frame_done); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL flush_word left=%0d exp=0", exp_q.size()); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] w;
    bit ok;
    bus.wr_ready = 1'b0;
    bus.sobel_vsync = 1'b1; tick(1);
    bus.sobel_hsync = 1'b1;
    for (int i = 0; i < 21; i++) px(1'b1);
    tick(2);
    total_cnt++; if (bus.wr_valid !== 1'b1) $display("FAIL rst_pre_queued wr_valid=%b exp=1", bus.wr_valid); else pass_cnt++;
    reset_p = 1'b1; tick(1); reset_p = 1'b0;
    total_cnt++; if (bus.wr_valid !== 1'b0) $display("FAIL rst_mid_wr_valid got=%b exp=0", bus.wr_valid); else pass_cnt++;
    total_cnt++; if (bus.wr_data !== 8'h00) $display("FAIL rst_mid_wr_data got=%h exp=00", bus.wr_data); else pass_cnt++;
    // vsync never dropped, so these pixels belong to no frame
    for (int i = 0; i < 8; i++) px(1'b1);
    tick(2);
    total_cnt++; if (bus.wr_valid !== 1'b0) $display("FAIL rst_wait_vsync wr_valid=%b exp=0", bus.wr_valid); else pass_cnt++;
    bus.sobel_hsync = 1'b0; bus.sobel_vsync = 1'b0; tick(1);
    fd_cnt = 0;
    bus.sobel_vsync = 1'b1; tick(1);
    bus.sobel_hsync = 1'b1;
    w = 8'h3C;
    exp_q.push_back({16'd0, w});
    bus.wr_ready = 1'b1;
    for (int i = 0; i < PW; i++) px(w[i]);
    bus.sobel_hsync = 1'b0; bus.sobel_vsync = 1'b0; tick(1);
    wait_drain(50, ok); tick(4);
    total_cnt++; if (!ok) $display("FAIL rst_next_frame left=%0d exp=0", exp_q.size()); else pass_cnt++;
    total_cnt++; if (fd_cnt != 1) $display("FAIL rst_frame_done pulses=%0d exp=1", fd_cnt); else pass_cnt++;
  endtask

  initial begin
    bus.sobel = 1'b0;
    bus.sobel_valid = 1'b0;
    bus.sobel_hsync = 1'b0;
    bus.sobel_vsync = 1'b0;
    bus.wr_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_line_pad();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
